// File: rtl/fnd_result_display_if.sv
//------------------------------------------------------------------------------
// fnd_result_display_if : adder-result capture bus and FND pin bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fnd_result_display_if;
    logic       result_valid;
    logic [4:0] result;
    logic [3:0] fnd_com;
    logic [7:0] fnd_font;

    modport master (
        output result_valid,
        output result,
        input  fnd_com,
        input  fnd_font
    );

    modport slave (
        input  result_valid,
        input  result,
        output fnd_com,
        output fnd_font
    );
endinterface

`default_nettype wire

// File: rtl/fnd_result_display.sv
//------------------------------------------------------------------------------
// fnd_result_display : captures a 5-bit adder result and scans it as decimal
//                      onto a 4-digit common-anode 7-segment display.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fnd_result_display #(
    parameter int SCAN_DIV = 100000
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    fnd_result_display_if.slave  bus
);

    localparam int             PW   = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  TERM = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2,
        D3 = 2'd3
    } digit_e;

    digit_e        state_q, state_d;
    logic [4:0]    value_q;
    logic [PW-1:0] presc_q;
    logic [3:0]    com_q, com_d;
    logic [7:0]    font_q, font_d;
    logic          tick;
    logic [3:0]    tens, ones;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    assign tick = (presc_q == TERM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= 5'd0;
            presc_q <= '0;
            state_q <= D0;
            com_q   <= 4'b1111;
            font_q  <= 8'hFF;
        end else begin
            if (bus.result_valid)
                value_q <= bus.result;
            presc_q <= tick ? '0 : presc_q + 1'b1;
            state_q <= state_d;
            com_q   <= com_d;
            font_q  <= font_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                D0:      state_d = D1;
                D1:      state_d = D2;
                D2:      state_d = D3;
                default: state_d = D0;
            endcase
        end
    end

    // Value is at most 31, so three compare-subtract stages cover all tens digits.
    always_comb begin
        tens = 4'd0;
        ones = value_q[3:0];
        if (value_q >= 5'd30) begin
            tens = 4'd3;
            ones = 4'(value_q - 5'd30);
        end else if (value_q >= 5'd20) begin
            tens = 4'd2;
            ones = 4'(value_q - 5'd20);
        end else if (value_q >= 5'd10) begin
            tens = 4'd1;
            ones = 4'(value_q - 5'd10);
        end
    end

    always_comb begin
        com_d  = ~(4'b0001 << state_q);
        font_d = 8'hFF;
        case (state_q)
            D0:      font_d = seg7(ones);
            D1:      font_d = (tens != 4'd0) ? seg7(tens) : 8'hFF;
            D2:      font_d = 8'hFF;
            default: font_d = value_q[4] ? 8'h7F : 8'hFF;
        endcase
    end

    assign bus.fnd_com  = com_q;
    assign bus.fnd_font = font_q;

endmodule

`default_nettype wire

// File: tb/tb_fnd_result_display.sv
//------------------------------------------------------------------------------
// tb_fnd_result_display : directed scoreboard bench for fnd_result_display
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fnd_result_display;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct {
        logic [3:0] com;
        logic [7:0] font;
    } slot_t;

    slot_t sb[$];

    fnd_result_display_if bus ();

    fnd_result_display #(.SCAN_DIV(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] font_of(input int d);
        logic [7:0] tbl [10];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return tbl[d];
    endfunction

    task automatic push_expected(input int v);
        slot_t s;
        s.com = 4'b1110; s.font = font_of(v % 10);                         sb.push_back(s);
        s.com = 4'b1101; s.font = (v / 10 == 0) ? 8'hFF : font_of(v / 10); sb.push_back(s);
        s.com = 4'b1011; s.font = 8'hFF;                                   sb.push_back(s);
        s.com = 4'b0111; s.font = (v >= 16) ? 8'h7F : 8'hFF;               sb.push_back(s);
    endtask

    task automatic wait_d0_start();
        logic [3:0] prev;
        bit         found;
        found = 1'b0;
        @(negedge clk);
        prev = bus.fnd_com;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.fnd_com == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = bus.fnd_com;
        end
        chk("d0_align_timeout", {7'd0, found}, 8'd1);
    endtask

    // Each slot must hold its digit for exactly SCAN_DIV clocks before moving on.
    task automatic check_scan(input int v, input bit aligned);
        slot_t e;
        push_expected(v);
        if (!aligned) wait_d0_start();
        for (int s = 0; s < 4; s++) begin
            e = sb.pop_front();
            for (int c = 0; c < 4; c++) begin
                if (s != 0 || c != 0) @(negedge clk);
                chk($sformatf("v%0d_slot%0d_com", v, s), {4'd0, bus.fnd_com}, {4'd0, e.com});
                chk($sformatf("v%0d_slot%0d_font", v, s), bus.fnd_font, e.font);
            end
        end
    endtask

    task automatic capture(input logic [4:0] v);
        @(negedge clk);
        bus.result       = v;
        bus.result_valid = 1'b1;
        @(negedge clk);
        bus.result_valid = 1'b0;
    endtask

    initial begin
        bus.result_valid = 1'b0;
        bus.result       = 5'd0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_com", {4'd0, bus.fnd_com}, 8'h0F);
            chk("reset_font", bus.fnd_font, 8'hFF);
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_com", {4'd0, bus.fnd_com}, 8'h0E);
        chk("post_reset_font", bus.fnd_font, 8'hC0);
        check_scan(0, 1'b1);

        capture(5'd7);   check_scan(7, 1'b0);
        capture(5'd14);  check_scan(14, 1'b0);
        capture(5'd18);  check_scan(18, 1'b0);

        // Strobe at the start of a D0 slot: the font changes one clock after the capture edge.
        wait_d0_start();
        bus.result       = 5'd15;
        bus.result_valid = 1'b1;
        @(negedge clk);
        bus.result_valid = 1'b0;
        chk("strobe_lag_old", bus.fnd_font, 8'h80);
        @(negedge clk);
        chk("strobe_lag_new", bus.fnd_font, 8'h92);
        check_scan(15, 1'b0);

        @(negedge clk);
        bus.result = 5'd31;
        repeat (6) @(negedge clk);
        check_scan(15, 1'b0);

        capture(5'd0);   check_scan(0, 1'b0);
        capture(5'd31);  check_scan(31, 1'b0);
        capture(5'd9);   check_scan(9, 1'b0);
        capture(5'd10);  check_scan(10, 1'b0);

        // Held valid keeps recapturing; the last value presented wins.
        @(negedge clk);
        bus.result_valid = 1'b1;
        bus.result = 5'd3;  @(negedge clk);
        bus.result = 5'd22; @(negedge clk);
        bus.result = 5'd27; @(negedge clk);
        bus.result_valid = 1'b0;
        bus.result = 5'd1;
        check_scan(27, 1'b0);

        begin : mid_scan_reset
            bit found;
            found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                @(negedge clk);
                if (bus.fnd_com == 4'b1011) found = 1'b1;
            end
            chk("d2_wait_timeout", {7'd0, found}, 8'd1);
        end
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_com", {4'd0, bus.fnd_com}, 8'h0F);
        chk("async_reset_font", bus.fnd_font, 8'hFF);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rerelease_com", {4'd0, bus.fnd_com}, 8'h0E);
        chk("rerelease_font", bus.fnd_font, 8'hC0);
        check_scan(0, 1'b1);

        chk("scoreboard_empty", 8'(sb.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
